// File: rtl/ch_measure_pkg.sv
// ch_measure_pkg
// Shared definitions for the channel measurement controller: datapath widths,
// reset defaults for the step registers and strobe timeout, the controller
// state encoding, and a helper that keeps step values non-zero.
package ch_measure_pkg;

    localparam int TH_W = 16;
    localparam int DC_W = 10;

    localparam logic [TH_W-1:0] TH_DELTA_RST_DEF = 16'd256;
    localparam logic [DC_W-1:0] DC_DELTA_RST_DEF = 10'd1;
    localparam int              STB_TIMEOUT_DEF  = 64;

    typedef enum logic [2:0] {
        IDLE,
        SET_TH,
        WAIT_RDY_LO,
        WAIT_RDY_HI,
        WAIT_STB,
        EVAL,
        EMIT
    } state_e;

    // A zero step would stall the threshold ramp or freeze the delay code,
    // so a written zero is promoted to one.
    function automatic logic [TH_W-1:0] stepOrOne(input logic [TH_W-1:0] step);
        return (step == '0) ? TH_W'(1) : step;
    endfunction

endpackage

// File: rtl/ch_sync2.sv
// ch_sync2
// Two-flop synchroniser bringing an asynchronous level into the clk_i domain.
// Ports:
//   clk_i  - system clock
//   arst_i - synchronous active-high reset, clears both stages
//   d_i    - asynchronous input level
//   q_o    - synchronised level, two clk_i cycles behind d_i
module ch_sync2 (
    input  logic clk_i,
    input  logic arst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First stage may go metastable; the second stage gives it a full cycle
    // to resolve before anything downstream looks at the value.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ch_measure_ctl.sv
// ch_measure_ctl
// Sweeps a DAC threshold upward for each delay-line code until the comparator
// reports the signal at or below the threshold, then emits a (voltage, time)
// point and advances the delay code.
// Ports:
//   clk_i, arst_i                      - clock, synchronous active-high reset
//   run_i                              - keep acquiring points while high
//   stb_i, cmp_out_i, threshold_rdy_i  - asynchronous strobe, comparator, DAC-ready
//   threshold_o, threshold_wre_o       - DAC code and one-cycle write pulse
//   threshold_delta_i/_wr_i            - threshold step value and load strobe
//   d_code_delta_i/_wr_i               - delay-code step value and load strobe
//   d_code_o                           - delay-line code for the current point
//   point_rdy_o, point_v_o, point_t_o  - point valid pulse, voltage, delay code
module ch_measure_ctl
    import ch_measure_pkg::*;
#(
    parameter logic [TH_W-1:0] TH_DELTA_RST = TH_DELTA_RST_DEF,
    parameter logic [DC_W-1:0] DC_DELTA_RST = DC_DELTA_RST_DEF,
    parameter int              STB_TIMEOUT  = STB_TIMEOUT_DEF
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            run_i,
    input  logic            stb_i,
    input  logic            cmp_out_i,
    output logic [TH_W-1:0] threshold_o,
    output logic            threshold_wre_o,
    input  logic            threshold_rdy_i,
    input  logic [TH_W-1:0] threshold_delta_i,
    input  logic            threshold_delta_wr_i,
    input  logic [DC_W-1:0] d_code_delta_i,
    input  logic            d_code_delta_wr_i,
    output logic [DC_W-1:0] d_code_o,
    output logic            point_rdy_o,
    output logic [TH_W-1:0] point_v_o,
    output logic [DC_W-1:0] point_t_o
);

    localparam int CNT_W = $clog2(STB_TIMEOUT + 1);

    logic stbSync;
    logic cmpSync;
    logic rdySync;

    ch_sync2 uStbSync (.clk_i(clk_i), .arst_i(arst_i), .d_i(stb_i),           .q_o(stbSync));
    ch_sync2 uCmpSync (.clk_i(clk_i), .arst_i(arst_i), .d_i(cmp_out_i),       .q_o(cmpSync));
    ch_sync2 uRdySync (.clk_i(clk_i), .arst_i(arst_i), .d_i(threshold_rdy_i), .q_o(rdySync));

    state_e            state_q,     state_d;
    logic [TH_W-1:0]   threshold_q, threshold_d;
    logic [DC_W-1:0]   dCode_q,     dCode_d;
    logic [TH_W-1:0]   thDelta_q,   thDelta_d;
    logic [DC_W-1:0]   dcDelta_q,   dcDelta_d;
    logic [TH_W-1:0]   pointV_q,    pointV_d;
    logic [DC_W-1:0]   pointT_q,    pointT_d;
    logic              cmpCap_q,    cmpCap_d;
    logic [CNT_W-1:0]  toCnt_q,     toCnt_d;
    logic              stbPrev_q;
    logic              stbEvent;
    logic [TH_W:0]     thSum;
    logic              thWre;
    logic              pointRdy;

    assign stbEvent = stbSync & ~stbPrev_q;
    // Extra carry bit tells us whether the next threshold still fits in TH_W.
    assign thSum    = {1'b0, threshold_q} + {1'b0, thDelta_q};

    // All state lives here; reset wins over every other input.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            threshold_q <= '0;
            dCode_q     <= '0;
            thDelta_q   <= TH_DELTA_RST;
            dcDelta_q   <= DC_DELTA_RST;
            pointV_q    <= '0;
            pointT_q    <= '0;
            cmpCap_q    <= 1'b0;
            toCnt_q     <= '0;
            stbPrev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            threshold_q <= threshold_d;
            dCode_q     <= dCode_d;
            thDelta_q   <= thDelta_d;
            dcDelta_q   <= dcDelta_d;
            pointV_q    <= pointV_d;
            pointT_q    <= pointT_d;
            cmpCap_q    <= cmpCap_d;
            toCnt_q     <= toCnt_d;
            stbPrev_q   <= stbSync;
        end
    end

    // Next-state and datapath updates. The write pulse and point pulse are
    // decoded from distinct states, so they can never overlap.
    always_comb begin
        state_d     = state_q;
        threshold_d = threshold_q;
        dCode_d     = dCode_q;
        thDelta_d   = thDelta_q;
        dcDelta_d   = dcDelta_q;
        pointV_d    = pointV_q;
        pointT_d    = pointT_q;
        cmpCap_d    = cmpCap_q;
        toCnt_d     = '0;
        thWre       = 1'b0;
        pointRdy    = 1'b0;

        if (threshold_delta_wr_i) begin
            thDelta_d = stepOrOne(threshold_delta_i);
        end
        if (d_code_delta_wr_i) begin
            dcDelta_d = (d_code_delta_i == '0) ? DC_W'(1) : d_code_delta_i;
        end

        case (state_q)
            IDLE: begin
                if (run_i) begin
                    threshold_d = '0;
                    state_d     = SET_TH;
                end
            end
            SET_TH: begin
                thWre   = 1'b1;
                state_d = WAIT_RDY_LO;
            end
            // Seeing ready drop first guarantees we wait for this write to
            // settle rather than trusting a stale ready from the last one.
            WAIT_RDY_LO: begin
                if (!rdySync) state_d = WAIT_RDY_HI;
            end
            WAIT_RDY_HI: begin
                if (rdySync) state_d = WAIT_STB;
            end
            WAIT_STB: begin
                if (stbEvent || (toCnt_q == CNT_W'(STB_TIMEOUT - 1))) begin
                    cmpCap_d = cmpSync;
                    state_d  = EVAL;
                end else begin
                    toCnt_d = toCnt_q + CNT_W'(1);
                end
            end
            EVAL: begin
                if (!cmpCap_q) begin
                    pointV_d = threshold_q;
                    pointT_d = dCode_q;
                    state_d  = EMIT;
                end else if (!thSum[TH_W]) begin
                    threshold_d = thSum[TH_W-1:0];
                    state_d     = SET_TH;
                end else begin
                    threshold_d = '1;
                    pointV_d    = '1;
                    pointT_d    = dCode_q;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                pointRdy    = 1'b1;
                dCode_d     = dCode_q + dcDelta_q;
                threshold_d = '0;
                state_d     = run_i ? SET_TH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign threshold_o     = threshold_q;
    assign threshold_wre_o = thWre;
    assign d_code_o        = dCode_q;
    assign point_rdy_o     = pointRdy;
    assign point_v_o       = pointV_q;
    assign point_t_o       = pointT_q;

endmodule

// File: tb/tb_ch_measure_ctl.sv
// tb_ch_measure_ctl
// Directed bench for ch_measure_ctl with a DAC/comparator/strobe model and a
// scoreboard of expected DAC writes and emitted points.
module tb_ch_measure_ctl;

    logic        clk;
    logic        arst_i = 1'b1;
    logic        run_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        cmp_out_i = 1'b0;
    logic        threshold_rdy_i = 1'b1;
    logic [15:0] threshold_delta_i = '0;
    logic        threshold_delta_wr_i = 1'b0;
    logic [9:0]  d_code_delta_i = '0;
    logic        d_code_delta_wr_i = 1'b0;
    logic [15:0] threshold_o;
    logic        threshold_wre_o;
    logic [9:0]  d_code_o;
    logic        point_rdy_o;
    logic [15:0] point_v_o;
    logic [9:0]  point_t_o;

    int checks = 0;
    int failures = 0;

    logic [15:0] wreQ[$];
    logic [15:0] ptVQ[$];
    logic [9:0]  ptTQ[$];

    int sigLevel = 0;
    bit stbEnable = 1'b1;
    bit rdyHold = 1'b0;
    bit sbIgnore = 1'b0;
    int rdyCnt = 0;
    int stbPhase = 0;
    int cycleCnt = 0;
    int lastWreCycle = 0;
    int wreCount = 0;

    int thModel = 256;
    int dcStepModel = 1;
    int dcModel = 0;

    ch_measure_ctl dut (
        .clk_i               (clk),
        .arst_i              (arst_i),
        .run_i               (run_i),
        .stb_i               (stb_i),
        .cmp_out_i           (cmp_out_i),
        .threshold_o         (threshold_o),
        .threshold_wre_o     (threshold_wre_o),
        .threshold_rdy_i     (threshold_rdy_i),
        .threshold_delta_i   (threshold_delta_i),
        .threshold_delta_wr_i(threshold_delta_wr_i),
        .d_code_delta_i      (d_code_delta_i),
        .d_code_delta_wr_i   (d_code_delta_wr_i),
        .d_code_o            (d_code_o),
        .point_rdy_o         (point_rdy_o),
        .point_v_o           (point_v_o),
        .point_t_o           (point_t_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Comparator sees a signal at sigLevel; DAC drops ready for a few cycles
    // after each write (or indefinitely while rdyHold); strobe has period 8.
    always @(negedge clk) begin
        cmp_out_i = (int'({16'h0, threshold_o}) < sigLevel);
        if (threshold_wre_o) begin
            threshold_rdy_i = 1'b0;
            rdyCnt = 4;
        end else if (rdyCnt > 0) begin
            rdyCnt--;
        end else if (!rdyHold) begin
            threshold_rdy_i = 1'b1;
        end
        if (stbEnable) begin
            stbPhase++;
            stb_i = stbPhase[2];
        end else begin
            stb_i = 1'b0;
        end
    end

    // Scoreboard: every DAC write and every point must match the queued model.
    always @(negedge clk) begin : monitor
        logic [15:0] expV;
        logic [9:0]  expT;
        if (!sbIgnore) begin
            if (threshold_wre_o || point_rdy_o)
                checkOutput("wre_rdy_exclusive", 32'(threshold_wre_o & point_rdy_o), 32'd0);
            if (threshold_wre_o) begin
                wreCount++;
                lastWreCycle = cycleCnt;
                checkOutput("wre_expected", 32'(wreQ.size() != 0), 32'd1);
                if (wreQ.size() != 0) begin
                    expV = wreQ.pop_front();
                    checkOutput("wre_threshold", 32'(threshold_o), 32'(expV));
                    checkOutput("wre_dcode", 32'(d_code_o), 32'(dcModel));
                end
            end
            if (point_rdy_o) begin
                checkOutput("point_expected", 32'(ptVQ.size() != 0), 32'd1);
                if (ptVQ.size() != 0) begin
                    expV = ptVQ.pop_front();
                    expT = ptTQ.pop_front();
                    checkOutput("point_v", 32'(point_v_o), 32'(expV));
                    checkOutput("point_t", 32'(point_t_o), 32'(expT));
                end
            end
        end
    end

    // Reference sweep: ramp from 0 while the comparator says signal > threshold.
    task automatic pushSweep(input int level);
        int t = 0;
        while (1) begin
            wreQ.push_back(16'(t));
            if (t < level) begin
                if (t + thModel <= 65535) begin
                    t = t + thModel;
                end else begin
                    t = 65535;
                    break;
                end
            end else begin
                break;
            end
        end
        ptVQ.push_back(16'(t));
        ptTQ.push_back(10'(dcModel));
    endtask

    task automatic waitPoint(input bit keepRun, output int gap);
        bit found = 1'b0;
        gap = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (point_rdy_o) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("point_seen", 32'(found), 32'd1);
        if (found) begin
            gap = cycleCnt - lastWreCycle;
            run_i = keepRun;
            dcModel = (dcModel + dcStepModel) % 1024;
        end else begin
            run_i = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int level, input bit keepRun, output int gap);
        sigLevel = level;
        pushSweep(level);
        run_i = 1'b1;
        waitPoint(keepRun, gap);
    endtask

    task automatic writeDeltas(input bit thWr, input logic [15:0] thV, input bit dcWr, input logic [9:0] dcV);
        @(negedge clk);
        threshold_delta_wr_i = thWr;
        threshold_delta_i = thV;
        d_code_delta_wr_i = dcWr;
        d_code_delta_i = dcV;
        @(negedge clk);
        threshold_delta_wr_i = 1'b0;
        d_code_delta_wr_i = 1'b0;
        if (thWr) thModel = (thV == 16'd0) ? 1 : int'(thV);
        if (dcWr) dcStepModel = (dcV == 10'd0) ? 1 : int'(dcV);
    endtask

    initial begin
        int gap;
        int wb;

        repeat (2) @(negedge clk);
        checkOutput("rst_threshold", 32'(threshold_o), 32'd0);
        checkOutput("rst_wre", 32'(threshold_wre_o), 32'd0);
        checkOutput("rst_dcode", 32'(d_code_o), 32'd0);
        checkOutput("rst_point_rdy", 32'(point_rdy_o), 32'd0);
        checkOutput("rst_point_v", 32'(point_v_o), 32'd0);
        checkOutput("rst_point_t", 32'(point_t_o), 32'd0);
        arst_i = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] default ramp, back-to-back sweeps");
        applyStimulus(1000, 1'b1, gap);
        applyStimulus(300, 1'b0, gap);

        $display("[TB] strobe timeout");
        stbEnable = 1'b0;
        applyStimulus(0, 1'b0, gap);
        checkOutput("timeout_gap_min", 32'(gap >= 64), 32'd1);
        checkOutput("timeout_gap_max", 32'(gap <= 90), 32'd1);
        stbEnable = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(0, 1'b0, gap);
        checkOutput("strobe_gap_short", 32'(gap < 64), 32'd1);

        $display("[TB] saturation and zero steps");
        writeDeltas(1'b1, 16'h5555, 1'b1, 10'd0);
        applyStimulus(65536, 1'b0, gap);
        writeDeltas(1'b1, 16'd0, 1'b1, 10'(1023 - dcModel));
        applyStimulus(2, 1'b0, gap);

        $display("[TB] delay code wrap");
        writeDeltas(1'b1, 16'd256, 1'b1, 10'd3);
        applyStimulus(0, 1'b0, gap);
        @(negedge clk);
        checkOutput("dcode_wrap", 32'(d_code_o), 32'd2);

        $display("[TB] ready stall and run drop mid-sweep");
        rdyHold = 1'b1;
        sigLevel = 1000;
        pushSweep(1000);
        wb = wreCount;
        run_i = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("rdy_hold_single_wre", 32'(wreCount - wb), 32'd1);
        run_i = 1'b0;
        repeat (5) @(negedge clk);
        rdyHold = 1'b0;
        waitPoint(1'b0, gap);
        wb = wreCount;
        repeat (100) @(negedge clk);
        checkOutput("idle_no_wre", 32'(wreCount - wb), 32'd0);
        checkOutput("point_v_hold", 32'(point_v_o), 32'd1024);
        checkOutput("point_t_hold", 32'(point_t_o), 32'd2);

        $display("[TB] reset mid-sweep");
        sbIgnore = 1'b1;
        sigLevel = 1000;
        run_i = 1'b1;
        repeat (30) @(negedge clk);
        arst_i = 1'b1;
        run_i = 1'b0;
        @(negedge clk);
        checkOutput("midrst_threshold", 32'(threshold_o), 32'd0);
        checkOutput("midrst_wre", 32'(threshold_wre_o), 32'd0);
        checkOutput("midrst_dcode", 32'(d_code_o), 32'd0);
        checkOutput("midrst_point_rdy", 32'(point_rdy_o), 32'd0);
        checkOutput("midrst_point_v", 32'(point_v_o), 32'd0);
        checkOutput("midrst_point_t", 32'(point_t_o), 32'd0);
        arst_i = 1'b0;
        wreQ.delete();
        ptVQ.delete();
        ptTQ.delete();
        thModel = 256;
        dcStepModel = 1;
        dcModel = 0;
        repeat (3) @(negedge clk);
        sbIgnore = 1'b0;

        applyStimulus(600, 1'b0, gap);
        @(negedge clk);
        checkOutput("dcode_after_reset", 32'(d_code_o), 32'(dcModel));

        repeat (5) @(negedge clk);
        checkOutput("queues_drained", 32'(wreQ.size() + ptVQ.size() + ptTQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
